mmio_bus_hub: RTL

MMIO_BUS_HUB -- requirements
Module: mmio_bus_hub

---
 rtl/bus_pkg.sv | 16 +
 rtl/mmio_bus_hub.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the MMIO bus hub: FSM state encoding and
// the slave-index width helper.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // A single slave still needs one index bit so the decode field is never empty.
  function automatic int idx_width(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/mmio_bus_hub.sv
// Single-master MMIO hub: decodes the master address into a region, strobes
// one slave, waits for its ready (bounded) and returns a one-cycle response.
module mmio_bus_hub
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int NUM_SLAVES     = 4,
  parameter int REGION_LSB     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            m_addr,
  input  logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_read,
  input  logic                             m_write,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             m_ready,
  output logic                             m_error,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic [REGION_LSB-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  output logic                             s_read,
  output logic                             s_write,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  output logic [7:0]                       err_count
);

  localparam int IDX_W  = idx_width(NUM_SLAVES);
  localparam int HI_LSB = REGION_LSB + IDX_W;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W:0]   NUM_S    = NUM_SLAVES[IDX_W:0];
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_next;
  logic [REGION_LSB-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic                    lat_write;
  logic [IDX_W-1:0]        lat_idx;
  logic [CNT_W-1:0]        wait_cnt;

  logic [IDX_W-1:0]        req_idx;
  logic                    req_hit;
  logic                    req_valid;
  logic                    slave_ready;
  logic [DATA_WIDTH-1:0]   slave_rdata;
  logic                    fin_err;
  logic [DATA_WIDTH-1:0]   fin_rdata;

  // Hit needs the index in range and every address bit above the index field clear.
  assign req_idx   = m_addr[REGION_LSB +: IDX_W];
  assign req_hit   = ({1'b0, req_idx} < NUM_S) && ((m_addr >> HI_LSB) == '0);
  assign req_valid = m_read ^ m_write;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    s_sel       = '0;
    slave_ready = 1'b0;
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (lat_idx == IDX_W'(i)) begin
        s_sel[i]    = (state == ACCESS);
        slave_ready = s_ready[i];
        slave_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign s_addr  = (state == ACCESS) ? lat_addr  : '0;
  assign s_wdata = (state == ACCESS) ? lat_wdata : '0;
  assign s_read  = (state == ACCESS) && !lat_write;
  assign s_write = (state == ACCESS) &&  lat_write;

  always_comb begin
    state_next = state;
    fin_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_read && m_write) begin
          state_next = DONE;
          fin_err    = 1'b1;
        end else if (req_valid) begin
          state_next = req_hit ? ACCESS : DONE;
          fin_err    = !req_hit;
        end
      end
      ACCESS: begin
        // Ready on the final allowed cycle still counts as a completion.
        if (slave_ready) begin
          state_next = DONE;
        end else if (wait_cnt == CNT_LAST) begin
          state_next = DONE;
          fin_err    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fin_rdata = (state == ACCESS && slave_ready && !lat_write) ? slave_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      wait_cnt  <= '0;
      m_ready   <= 1'b0;
      m_error   <= 1'b0;
      m_rdata   <= '0;
      err_count <= '0;
    end else begin
      state   <= state_next;
      m_ready <= 1'b0;
      m_error <= 1'b0;
      m_rdata <= '0;
      if (state == IDLE && req_valid) begin
        lat_addr  <= m_addr[REGION_LSB-1:0];
        lat_wdata <= m_wdata;
        lat_write <= m_write;
        lat_idx   <= req_idx;
      end
      wait_cnt <= (state == ACCESS) ? wait_cnt + 1'b1 : '0;
      if (state_next == DONE) begin
        m_ready <= 1'b1;
        m_error <= fin_err;
        m_rdata <= fin_rdata;
        if (fin_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
